// File: rtl/decoder_pkg.sv
// Shared decoder definitions: top-level state-bus encodings, frame geometry
// and the input-side controller state type.
package decoder_pkg;

  // Top-level decoder state bus
  localparam int unsigned STATE_WIDTH = 8;
  localparam logic [STATE_WIDTH-1:0] INPUT_STATE       = 8'd1;
  localparam logic [STATE_WIDTH-1:0] OUTPUT_WAIT_STATE = 8'd2;
  localparam logic [STATE_WIDTH-1:0] OUTPUT_STATE      = 8'd3;

  // Frame geometry
  localparam int unsigned CODE_LENGTH         = 1024;
  localparam int unsigned ADDR_WIDTH          = 10;
  localparam int unsigned DATA_WIDTH          = 8;
  localparam int unsigned INNER_COUNTER_WIDTH = 11;

  // Input controller FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } in_fsm_t;

endpackage

// File: rtl/input_controller.sv
// AXI4-Stream slave that stores one frame of CODE_LENGTH channel LLRs into the
// input buffer BRAM and pulses input_done when the frame is complete.
// Reception is only allowed while the top-level state bus equals INPUT_STATE.
// Optional tlast framing check: define INPUT_TLAST_CHECK_EN.
module input_controller #(
  parameter int unsigned CODE_LENGTH         = decoder_pkg::CODE_LENGTH,
  parameter int unsigned ADDR_WIDTH          = decoder_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH          = decoder_pkg::DATA_WIDTH,
  parameter int unsigned STATE_WIDTH         = decoder_pkg::STATE_WIDTH,
  parameter logic [STATE_WIDTH-1:0] INPUT_STATE = decoder_pkg::INPUT_STATE,
  parameter int unsigned INNER_COUNTER_WIDTH = decoder_pkg::INNER_COUNTER_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STATE_WIDTH-1:0] state,
  input  logic [DATA_WIDTH-1:0]  saxis_tdata,
  input  logic                   saxis_tvalid,
  input  logic                   saxis_tlast,
  output logic                   saxis_tready,
  output logic [DATA_WIDTH-1:0]  data_to_input_buffer_bram,
  output logic [ADDR_WIDTH-1:0]  addr_to_input_buffer_bram,
  output logic                   write_enable_to_input_buffer_bram,
  output logic                   input_done,
  output logic                   frame_error
);

  import decoder_pkg::*;

  localparam logic [INNER_COUNTER_WIDTH-1:0] LP_LAST_BEAT =
    INNER_COUNTER_WIDTH'(CODE_LENGTH - 1);
  localparam logic [INNER_COUNTER_WIDTH-1:0] LP_FULL =
    INNER_COUNTER_WIDTH'(CODE_LENGTH);

  in_fsm_t                        r_fsm;
  logic [INNER_COUNTER_WIDTH-1:0] r_counter;
  logic                           r_we;
  logic [ADDR_WIDTH-1:0]          r_addr;
  logic [DATA_WIDTH-1:0]          r_data;
  logic                           r_done;

  logic w_armed;
  logic w_tready;
  logic w_hs;
  logic w_last_beat;
  logic w_counter_full;

  // Handshake qualification; tready drops combinationally with the state bus
  always_comb begin
    w_armed        = (state == INPUT_STATE);
    w_tready       = ((r_fsm == RECV) || (r_fsm == DRAIN)) && w_armed;
    w_hs           = saxis_tvalid && w_tready;
    w_last_beat    = (r_counter == LP_LAST_BEAT);
    w_counter_full = (r_counter == LP_FULL);
  end

`ifdef INPUT_TLAST_CHECK_EN
  logic r_frame_error;

  // Sticky framing error, cleared when a new frame is armed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_error <= 1'b0;
    end else begin
      unique case (r_fsm)
        IDLE: begin
          if (w_armed) begin
            r_frame_error <= 1'b0;
          end
        end
        RECV: begin
          // Missing tlast on the final beat, or tlast before the final beat
          if (w_armed && w_hs && !w_counter_full &&
              (w_last_beat != saxis_tlast)) begin
            r_frame_error <= 1'b1;
          end
        end
        default: begin
          r_frame_error <= r_frame_error;
        end
      endcase
    end
  end

  assign frame_error = r_frame_error;
`else
  assign frame_error = 1'b0;
`endif

  // Frame FSM, beat counter and registered BRAM write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm     <= IDLE;
      r_counter <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_fsm)
        IDLE: begin
          if (w_armed) begin
            r_fsm     <= RECV;
            r_counter <= '0;
          end
        end
        RECV: begin
          if (!w_armed) begin
            r_fsm <= IDLE;
          end else if (w_hs) begin
            if (!w_counter_full) begin
              r_we      <= 1'b1;
              r_addr    <= r_counter[ADDR_WIDTH-1:0];
              r_data    <= saxis_tdata;
              r_counter <= r_counter + 1'b1;
            end
`ifdef INPUT_TLAST_CHECK_EN
            if (w_last_beat) begin
              if (saxis_tlast) begin
                r_fsm  <= DONE;
                r_done <= 1'b1;
              end else begin
                r_fsm <= DRAIN;
              end
            end else if (saxis_tlast) begin
              r_fsm  <= DONE;
              r_done <= 1'b1;
            end
`else
            if (w_last_beat) begin
              r_fsm  <= DONE;
              r_done <= 1'b1;
            end
`endif
          end
        end
        DRAIN: begin
          // Overrun beats are consumed but never written
          if (!w_armed) begin
            r_fsm <= IDLE;
          end else if (w_hs && saxis_tlast) begin
            r_fsm  <= DONE;
            r_done <= 1'b1;
          end
        end
        DONE: begin
          if (!w_armed) begin
            r_fsm <= IDLE;
          end
        end
        default: begin
          r_fsm <= IDLE;
        end
      endcase
    end
  end

  assign saxis_tready                      = w_tready;
  assign data_to_input_buffer_bram         = r_data;
  assign addr_to_input_buffer_bram         = r_addr;
  assign write_enable_to_input_buffer_bram = r_we;
  assign input_done                        = r_done;

endmodule

// File: tb/tb_input_controller.sv
// Self-checking bench for input_controller: randomized AXI4-Stream stimulus
// compared every cycle against a frame-level reference model.
module tb_input_controller;

  localparam int unsigned CL = 1024;
  localparam logic [7:0] IN_ST  = 8'd1;
  localparam logic [7:0] OFF_ST = 8'd0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] state = 8'd0;
  logic [7:0] saxis_tdata = 8'd0;
  logic       saxis_tvalid = 1'b0;
  logic       saxis_tlast = 1'b0;
  logic       saxis_tready;
  logic [7:0] data_to_input_buffer_bram;
  logic [9:0] addr_to_input_buffer_bram;
  logic       write_enable_to_input_buffer_bram;
  logic       input_done;
  logic       frame_error;

  int n_tests = 0;
  int n_fail  = 0;

  input_controller #(
    .CODE_LENGTH(1024),
    .ADDR_WIDTH(10),
    .DATA_WIDTH(8),
    .STATE_WIDTH(8),
    .INPUT_STATE(8'd1),
    .INNER_COUNTER_WIDTH(11)
  ) dut (
    .clk(clk),
    .reset(reset),
    .state(state),
    .saxis_tdata(saxis_tdata),
    .saxis_tvalid(saxis_tvalid),
    .saxis_tlast(saxis_tlast),
    .saxis_tready(saxis_tready),
    .data_to_input_buffer_bram(data_to_input_buffer_bram),
    .addr_to_input_buffer_bram(addr_to_input_buffer_bram),
    .write_enable_to_input_buffer_bram(write_enable_to_input_buffer_bram),
    .input_done(input_done),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (frame-level view) ----------------
  // m_open: frame window accepting beats; m_drain: overrun beats being
  // discarded; m_sealed: frame finished, waiting for the state bus to leave.
  int         m_beats = 0;
  bit         m_open = 1'b0, m_drain = 1'b0, m_sealed = 1'b0, m_hs = 1'b0;
  bit         m_armed_now = 1'b0;
  bit         exp_we = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
  logic [9:0] exp_addr = '0;
  logic [7:0] exp_data = '0;

  task automatic model_finish();
    m_open   = 1'b0;
    m_drain  = 1'b0;
    m_sealed = 1'b1;
    exp_done = 1'b1;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_beats = 0; m_open = 0; m_drain = 0; m_sealed = 0; m_hs = 0;
      exp_we = 0; exp_done = 0; exp_err = 0; exp_addr = '0; exp_data = '0;
    end else begin
      m_armed_now = (state == IN_ST);
      m_hs     = m_open && m_armed_now && saxis_tvalid;
      exp_we   = 1'b0;
      exp_done = 1'b0;
      if (m_open) begin
        if (!m_armed_now) begin
          m_open  = 1'b0;
          m_drain = 1'b0;
        end else if (m_hs) begin
          if (m_drain) begin
            if (saxis_tlast) model_finish();
          end else begin
            exp_we   = 1'b1;
            exp_addr = m_beats[9:0];
            exp_data = saxis_tdata;
            m_beats++;
`ifdef INPUT_TLAST_CHECK_EN
            if (m_beats == CL && !saxis_tlast) begin
              m_drain = 1'b1;
              exp_err = 1'b1;
            end else if (m_beats == CL || saxis_tlast) begin
              if (m_beats < CL) exp_err = 1'b1;
              model_finish();
            end
`else
            if (m_beats == CL) model_finish();
`endif
          end
        end
      end else if (m_sealed) begin
        if (!m_armed_now) m_sealed = 1'b0;
      end else if (m_armed_now) begin
        m_open  = 1'b1;
        m_beats = 0;
        exp_err = 1'b0;
      end
    end
  end

  // Single compare process against the model, mid-cycle
  always @(negedge clk) begin
    check("tready", saxis_tready, m_open && (state == IN_ST));
    check("we", write_enable_to_input_buffer_bram, exp_we);
    if (exp_we) begin
      check("addr", addr_to_input_buffer_bram, exp_addr);
      check("data", data_to_input_buffer_bram, exp_data);
    end
    check("done", input_done, exp_done);
    check("frame_error", frame_error, exp_err);
  end

  // ---------------- DUT activity observation ----------------
  int obs_epoch = 0;
  int cur_ep = -1;
  int n_wr = 0, n_done = 0, n_dup = 0, first_addr = -1, max_addr = -1;
  int last_ep[1024] = '{default: -1};

  always @(negedge clk) begin
    if (input_done === 1'b1) n_done++;
    if (write_enable_to_input_buffer_bram === 1'b1) begin
      if (cur_ep != obs_epoch) begin
        cur_ep     = obs_epoch;
        first_addr = int'(addr_to_input_buffer_bram);
        max_addr   = int'(addr_to_input_buffer_bram);
      end
      if (int'(addr_to_input_buffer_bram) > max_addr) max_addr = int'(addr_to_input_buffer_bram);
      if (last_ep[addr_to_input_buffer_bram] == obs_epoch) n_dup++;
      last_ep[addr_to_input_buffer_bram] = obs_epoch;
      n_wr++;
    end
  end

  int wr0 = 0, done0 = 0, dup0 = 0;

  task automatic begin_test();
    obs_epoch++;
    wr0   = n_wr;
    done0 = n_done;
    dup0  = n_dup;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer beats until n handshakes occurred (bounded)
  task automatic run_beats(input int n, input int pct_valid, input int tlast_idx, input bit rnd);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 20000) begin
      saxis_tvalid = ($urandom_range(99) < pct_valid);
      saxis_tdata  = rnd ? 8'($urandom) : i[7:0];
      saxis_tlast  = (i == tlast_idx);
      @(posedge clk);
      #1;
      if (m_hs) i++;
      guard++;
    end
    saxis_tvalid = 1'b0;
    saxis_tlast  = 1'b0;
    if (guard >= 20000) check("beat_timeout", i, n);
  endtask

  task automatic disarm();
    state = OFF_ST;
    step(3);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(3);
    check("rst_we", write_enable_to_input_buffer_bram, 0);
    check("rst_addr", addr_to_input_buffer_bram, 0);
    check("rst_data", data_to_input_buffer_bram, 0);
    check("rst_done", input_done, 0);
    check("rst_err", frame_error, 0);
    check("rst_tready", saxis_tready, 0);
    reset = 1'b1;
    step(2);

    // Nominal frame: data = beat index, tvalid always high
    begin_test();
    state = IN_ST;
    run_beats(CL, 100, CL - 1, 1'b0);
    check("nom_done_edge", input_done, 1);
    check("nom_last_we", write_enable_to_input_buffer_bram, 1);
    check("nom_last_addr", addr_to_input_buffer_bram, 1023);
    check("nom_last_data", data_to_input_buffer_bram, 8'd255);
    step(3);
    check("nom_writes", n_wr - wr0, 1024);
    check("nom_done_cnt", n_done - done0, 1);
    check("nom_tready", saxis_tready, 0);
    check("nom_err", frame_error, 0);
    check("nom_first", first_addr, 0);
    disarm();

    // Backpressure: tvalid at 50 percent, random data
    begin_test();
    state = IN_ST;
    run_beats(CL, 50, CL - 1, 1'b1);
    step(3);
    check("gap_writes", n_wr - wr0, 1024);
    check("gap_dups", n_dup - dup0, 0);
    check("gap_max", max_addr, 1023);
    check("gap_done_cnt", n_done - done0, 1);
    disarm();

    // Abort after 300 beats, then a full frame
    begin_test();
    state = IN_ST;
    run_beats(300, 70, -1, 1'b1);
    check("abort_tready_before", saxis_tready, 1);
    state = OFF_ST;
    #1;
    check("abort_tready_same_cycle", saxis_tready, 0);
    step(4);
    check("abort_writes", n_wr - wr0, 300);
    check("abort_no_done", n_done - done0, 0);
    begin_test();
    state = IN_ST;
    run_beats(CL, 80, CL - 1, 1'b1);
    step(2);
    check("rearm_first", first_addr, 0);
    check("rearm_writes", n_wr - wr0, 1024);
    check("rearm_done_cnt", n_done - done0, 1);
    disarm();

    // Early tlast on beat 511
    begin_test();
    state = IN_ST;
`ifdef INPUT_TLAST_CHECK_EN
    run_beats(512, 80, 511, 1'b1);
    step(3);
    check("early_writes", n_wr - wr0, 512);
    check("early_max", max_addr, 511);
    check("early_err", frame_error, 1);
    check("early_done_cnt", n_done - done0, 1);
`else
    run_beats(CL, 80, 511, 1'b1);
    step(3);
    check("early_ign_writes", n_wr - wr0, 1024);
    check("early_ign_err", frame_error, 0);
    check("early_ign_done_cnt", n_done - done0, 1);
`endif
    disarm();

    // Missing tlast on the final beat
    begin_test();
    state = IN_ST;
`ifdef INPUT_TLAST_CHECK_EN
    run_beats(CL + 3, 100, CL + 2, 1'b1);
    check("miss_done_edge", input_done, 1);
    step(3);
    check("miss_writes", n_wr - wr0, 1024);
    check("miss_err", frame_error, 1);
    check("miss_done_cnt", n_done - done0, 1);
`else
    run_beats(CL, 100, -1, 1'b1);
    step(3);
    check("notlast_writes", n_wr - wr0, 1024);
    check("notlast_err", frame_error, 0);
    check("notlast_done_cnt", n_done - done0, 1);
`endif
    disarm();

    // Reset mid-frame, with a write strobe in flight
    begin_test();
    state = IN_ST;
    run_beats(100, 100, -1, 1'b1);
    check("mid_we_before", write_enable_to_input_buffer_bram, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_we", write_enable_to_input_buffer_bram, 0);
    check("mid_rst_addr", addr_to_input_buffer_bram, 0);
    check("mid_rst_data", data_to_input_buffer_bram, 0);
    check("mid_rst_done", input_done, 0);
    check("mid_rst_err", frame_error, 0);
    check("mid_rst_tready", saxis_tready, 0);
    step(2);
    reset = 1'b1;
    #0;
    check("mid_idle_tready", saxis_tready, 0);
    begin_test();
    run_beats(CL, 90, CL - 1, 1'b1);
    step(2);
    check("post_rst_first", first_addr, 0);
    check("post_rst_writes", n_wr - wr0, 1024);
    check("post_rst_done_cnt", n_done - done0, 1);
    disarm();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_controller.md
Name: input_controller

Overview:
- AXI4-Stream slave that receives one frame of CODE_LENGTH channel LLRs and writes them into the input buffer BRAM.
- Counterpart of the output-side streaming controller. Armed by the top-level decoder state bus.
- Signals frame completion to the decoder FSM via a one-cycle input_done pulse.
- Optionally checks tlast framing.

Parameters:
- CODE_LENGTH, 1024, beats per frame
- ADDR_WIDTH, 10, input buffer BRAM address width
- DATA_WIDTH, 8, LLR width per beat
- STATE_WIDTH, 8, width of the top-level state bus
- INPUT_STATE, 8'd1, state-bus encoding during which reception is allowed
- INNER_COUNTER_WIDTH, 11, beat counter width; must hold CODE_LENGTH

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- state  in  STATE_WIDTH  top-level decoder state
- saxis_tdata  in  DATA_WIDTH  LLR beat
- saxis_tvalid  in  1  beat valid
- saxis_tlast  in  1  last beat of frame
- saxis_tready  out  1  ready
- data_to_input_buffer_bram  out  DATA_WIDTH  write data
- addr_to_input_buffer_bram  out  ADDR_WIDTH  write address
- write_enable_to_input_buffer_bram  out  1  write strobe
- input_done  out  1  one-cycle pulse when the frame is stored
- frame_error  out  1  sticky tlast framing error; only driven when INPUT_TLAST_CHECK_EN is defined, else 0

Behaviour:
- Reset (reset=0, async): FSM=IDLE, counter=0. All registered outputs go to 0: BRAM data, address, write enable, input_done, frame_error.
- Internal FSM states: IDLE, RECV, DRAIN, DONE.
- saxis_tready = (fsm==RECV || fsm==DRAIN) && (state==INPUT_STATE). It is combinational, so no beat is accepted in the cycle state leaves INPUT_STATE.
- Handshake: a beat is consumed when tvalid && tready. tdata must not be sampled otherwise.
- IDLE:
  - When state==INPUT_STATE: go to RECV, clear counter and frame_error.
- RECV, on each handshake:
  - BRAM write registered with 1-cycle latency: next cycle we=1, addr=counter[ADDR_WIDTH-1:0], data=tdata.
  - counter+1.
  - we=0 in every cycle without a handshake.
- RECV, beat with counter==CODE_LENGTH-1: after its handshake go to DONE. With the check enabled, if tlast=0 on this beat, go to DRAIN instead.
- DRAIN (check enabled only):
  - Accept and discard beats; no BRAM writes.
  - Set frame_error.
  - Leave to DONE on the handshake of a beat with tlast=1.
- DONE:
  - input_done=1 for exactly the first cycle in DONE; it coincides with the final BRAM write strobe of the frame.
  - tready=0.
  - Return to IDLE when state!=INPUT_STATE.
- Abort: if state!=INPUT_STATE while in RECV or DRAIN, go to IDLE next cycle.
  - No input_done.
  - A write already registered still completes.
  - The partial frame is discarded; the next arm restarts at address 0.
- Back-to-back frames: a new frame requires the state bus to leave and re-enter INPUT_STATE.
- Counter never wraps: it saturates at CODE_LENGTH, and no writes happen beyond address CODE_LENGTH-1.

Optional Feature:
- Macro: INPUT_TLAST_CHECK_EN.
- Defined:
  - tlast=1 on a beat with counter<CODE_LENGTH-1 sets frame_error. That beat is written, then go to DONE (early termination, input_done still pulses).
  - Missing tlast on beat CODE_LENGTH-1 sets frame_error and goes to DRAIN.
- Undefined:
  - tlast is ignored and the frame is delimited purely by count.
  - DRAIN is unreachable; frame_error is tied to 0.

Decomposition:
- Shared package decoder_pkg holds:
  - top-level state encodings (INPUT_STATE, OUTPUT_WAIT_STATE, OUTPUT_STATE) as STATE_WIDTH constants
  - CODE_LENGTH, ADDR_WIDTH, LLR DATA_WIDTH
  - enum typedef in_fsm_t {IDLE, RECV, DRAIN, DONE}
- No sub-module. The FSM, counter and write register stay in one module.

Test Plan:
- Nominal frame:
  - Stimulus: state=INPUT_STATE; 1024 beats with tdata=i[7:0], tvalid always 1, tlast on beat 1023.
  - Required response:
    - 1024 writes with addr i and data i.
    - input_done pulses once, one cycle after the beat-1023 handshake.
    - tready=0 afterwards; frame_error=0.
- Backpressure/gaps:
  - Stimulus: tvalid toggled pseudo-randomly at 50%.
  - Required response: writes occur only one cycle after each handshake; addresses are contiguous 0..1023 with no duplicates.
- Abort:
  - Stimulus: state drops from INPUT_STATE after 300 beats, then is re-armed and a full frame is sent.
  - Required response:
    - tready falls in the same cycle; no input_done for the aborted frame.
    - Second frame writes start at addr 0.
- Early tlast (check enabled):
  - Stimulus: tlast on beat 511.
  - Required response:
    - Writes to addr 0..511 only.
    - frame_error=1; input_done pulses.
- Missing tlast (check enabled):
  - Stimulus: 1024 beats without tlast, then 3 extra beats, the third with tlast.
  - Required response:
    - Exactly 1024 writes; extra beats accepted but not written.
    - frame_error=1; input_done pulses after the tlast beat.
- Reset mid-frame:
  - Stimulus: reset=0 asserted after 100 beats.
  - Required response: all outputs go to 0 immediately (asynchronously); the FSM is in IDLE after reset=1.
